// File: rtl/pulse_train_gen.sv
// Rate-encoded pulse generator: spreads a requested count of single-cycle pulses
// evenly over a WINDOW-cycle window. Define PULSE_TRAIN_GEN_REPEAT_EN to re-arm automatically.
module pulse_train_gen #(
   parameter int WINDOW = 1000,
   parameter int VAL_W  = 12,
   parameter int ACC_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [VAL_W-1:0] value,
   input  logic             valid,
   output logic             ready,
   output logic             A,
   output logic             busy,
   output logic             window_done,
   output logic             sat
);

   localparam int               I_W    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
   localparam logic [I_W-1:0]   I_LAST = I_W'(WINDOW - 1);
   localparam logic [ACC_W-1:0] WIN_A  = ACC_W'(WINDOW);
   localparam logic [VAL_W-1:0] WIN_V  = VAL_W'(WINDOW);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state_reg, state_next;
   logic [I_W-1:0]   i_reg, i_next;
   logic [ACC_W-1:0] acc_reg, acc_next;
   logic [VAL_W-1:0] val_q_reg, val_q_next;
   logic             a_reg, a_next;
   logic             sat_reg, sat_next;
   logic             last_step;
   logic             accept;
   logic [ACC_W-1:0] sum;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         i_reg     <= '0;
         acc_reg   <= '0;
         val_q_reg <= '0;
         a_reg     <= 1'b0;
         sat_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         i_reg     <= i_next;
         acc_reg   <= acc_next;
         val_q_reg <= val_q_next;
         a_reg     <= a_next;
         sat_reg   <= sat_next;
      end
   end

   // Bresenham-style accumulator: one pulse each time the running sum crosses WINDOW.
   always_comb begin
      state_next = state_reg;
      i_next     = i_reg;
      acc_next   = acc_reg;
      val_q_next = val_q_reg;
      sat_next   = sat_reg;
      a_next     = 1'b0;
      sum        = acc_reg + ACC_W'(val_q_reg);
      if (state_reg == RUN) begin
         if (sum >= WIN_A) begin
            a_next   = 1'b1;
            acc_next = sum - WIN_A;
         end else begin
            acc_next = sum;
         end
         i_next = i_reg + 1'b1;
         if (last_step && !accept) begin
            i_next   = '0;
            acc_next = '0;
`ifndef PULSE_TRAIN_GEN_REPEAT_EN
            state_next = IDLE;
            sat_next   = 1'b0;
`endif
         end
      end
      // The trailing pulse of the old window (a_next above) survives a back-to-back accept.
      if (accept) begin
         val_q_next = (value > WIN_V) ? WIN_V : value;
         sat_next   = (value > WIN_V);
         i_next     = '0;
         acc_next   = '0;
         state_next = RUN;
      end
   end

   always_comb begin
      last_step   = (state_reg == RUN) && (i_reg == I_LAST);
      ready       = !rst && ((state_reg == IDLE) || last_step);
      accept      = valid && ready;
      busy        = (state_reg == RUN);
      window_done = last_step;
      A           = a_reg;
      sat         = sat_reg;
   end

endmodule

// File: doc/pulse_train_gen.md
Name: pulse_train_gen

Overview:
- Generator-side counterpart of the team's windowed pulse counter.
- Takes a 12-bit count over a valid/ready handshake.
- Emits exactly that many single-cycle pulses on `A`, spread evenly across a fixed window of WINDOW clock cycles.
- Feeds stimulus into the counter, or drives any downstream consumer that expects a rate-encoded pulse stream.

Parameters:
- WINDOW, 1000, window length in clk cycles; also the maximum pulse count per window.
- VAL_W, 12, width of `value`.
- ACC_W, 16, accumulator width; must hold 2*WINDOW-1.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- value  in  VAL_W  requested pulse count for the next window.
- valid  in  1  `value` is offered.
- ready  out  1  block accepts `value` this cycle.
- A  out  1  pulse output; high for one cycle per pulse.
- busy  out  1  window in progress.
- window_done  out  1  one-cycle strobe in the last cycle of each window.
- sat  out  1  latched value was clamped to WINDOW; held for that window.

Behaviour:
- Reset (async, rst=1): state=IDLE, i=0, acc=0, val_q=0. Outputs A=0, busy=0, window_done=0, sat=0; ready=1 once rst is released.
- States:
  - IDLE: ready=1, busy=0.
  - RUN: busy=1; ready=1 only when i==WINDOW-1, otherwise 0.
- Accept: valid && ready on a rising edge.
  - val_q <= min(value, WINDOW); sat <= (value > WINDOW).
  - i <= 0; acc <= 0; state <= RUN.
  - First window cycle is the next cycle.
- RUN, each cycle (A is registered):
  - s = acc + val_q.
  - If s >= WINDOW: A <= 1 and acc <= s - WINDOW. Else: A <= 0 and acc <= s.
  - i <= i+1.
  - A is therefore visible one cycle after the accumulation step. Window cycle k shows the pulse decision of step k-1. Window cycle 0 shows A=0.
- Window length is WINDOW cycles measured on A.
  - Pulses visible on A in one window = val_q exactly.
  - acc returns to 0 at window end.
- Last step (i==WINDOW-1):
  - window_done=1 for that cycle.
  - If valid: new window starts back-to-back, no gap cycle; the final A of the old window appears in the new window's cycle 0.
  - Else: state <= IDLE.
- Pulse spacing (decision index i):
  - val_q=WINDOW: pulse every step.
  - val_q=WINDOW/2: pulses on odd i.
  - val_q=1: single pulse at i=WINDOW-1.
  - val_q=0: no pulses.
- valid while ready=0: ignored and not accepted; the source must hold.
- rst mid-window: immediate return to IDLE. A drops asynchronously. The partial window is discarded; no window_done.
- The trailing A from the last step of a window is always driven, including when the next state is IDLE.
- Arithmetic: all unsigned. Clamp happens before latching. acc < WINDOW is invariant after each step.

Optional Feature:
- Macro: PULSE_TRAIN_GEN_REPEAT_EN.
- Defined: at window end with no valid, the block re-arms with the current val_q and sat. It keeps RUN with i=0, acc=0, so the pulse stream is continuous until reset. ready still follows the RUN rule.
- Not defined: at window end with no valid, the block returns to IDLE as above.

Test Plan:
- value=500, valid 1 cycle, WINDOW=1000 -> exactly 500 A pulses, alternating cycles; window_done once at the 1000th cycle after accept; busy then 0.
- value=0 -> A stays 0 for 1000 cycles; window_done pulses once; sat=0.
- value=4095 -> sat=1; A=1 on 1000 consecutive cycles (window cycles 1..999 plus next cycle); ready=0 except at i=999.
- value=3 then value=7 held valid -> second accepted at i=999; windows contiguous; pulse counts 3 and 7 per 1000-cycle span; acc=0 at each boundary.
- Accept value=200, assert rst at window cycle 400 -> A=0 immediately; busy=0; no window_done; after release, ready=1 and value=1 gives a single pulse 1000 cycles after accept.
- With PULSE_TRAIN_GEN_REPEAT_EN, value=10 once -> 10 pulses in each of 3 consecutive windows; window_done every 1000 cycles; busy stays 1.
